// File: rtl/system_state_if.sv
// Sensor/status bundle between the system state classifier and its environment.
// The master side drives the run request and samples; the slave side reports the state.
interface system_state_if #(
  parameter int DATA_W = 12
);
  logic              enable;
  logic              sensor_valid;
  logic [DATA_W-1:0] sensor_value;
  logic              fault_clear;
  logic [1:0]        system_state;
  logic              state_changed;
  logic [1:0]        fault_cause;

  modport master (
    output enable, sensor_valid, sensor_value, fault_clear,
    input  system_state, state_changed, fault_cause
  );

  modport slave (
    input  enable, sensor_valid, sensor_value, fault_clear,
    output system_state, state_changed, fault_cause
  );
endinterface

// File: rtl/system_state_fsm.sv
// Classifies sensor samples into IDLE/NORMAL/WARNING/FAULT with persistence,
// recovery hysteresis, a latched FAULT and a missing-sample watchdog.
module system_state_fsm #(
  parameter int DATA_W   = 12,
  parameter int WARN_TH  = 2048,
  parameter int FAULT_TH = 3072,
  parameter int HYST     = 128,
  parameter int PERSIST  = 3,
  parameter int TIMEOUT  = 1000
) (
  input logic           clk,
  input logic           reset,
  system_state_if.slave bus
);

  localparam int CNT_W = (PERSIST > 0) ? $clog2(PERSIST + 1) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [DATA_W:0]  FAULT_L   = (DATA_W+1)'(FAULT_TH);
  localparam logic [DATA_W:0]  WARN_L    = (DATA_W+1)'(WARN_TH);
  localparam logic [DATA_W:0]  OK_L      = (DATA_W+1)'(WARN_TH - HYST);
  localparam logic [CNT_W-1:0] PERSIST_L = CNT_W'(PERSIST);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_NORMAL  = 2'b01,
    S_WARNING = 2'b10,
    S_FAULT   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_THRESH = 2'b01,
    CAUSE_WDOG  = 2'b10
  } cause_t;

  state_t            state, state_n;
  state_t            cand, cand_n;   // S_IDLE doubles as "no candidate"
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [WD_W-1:0]   wd_cnt, wd_n;
  cause_t            cause, cause_n;
  logic              changed;

  state_t            target;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W:0]   value_ext;

  assign value_ext = {1'b0, bus.sensor_value};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cand    <= S_IDLE;
      cnt     <= '0;
      wd_cnt  <= '0;
      cause   <= CAUSE_NONE;
      changed <= 1'b0;
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      cnt     <= cnt_n;
      wd_cnt  <= wd_n;
      cause   <= cause_n;
      changed <= (state_n != state);
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    wd_n    = wd_cnt;
    cause_n = cause;
    target  = S_IDLE;
    cnt_inc = '0;

    case (state)
      S_IDLE: begin
        cand_n = S_IDLE;
        cnt_n  = '0;
        wd_n   = '0;
        if (bus.enable) state_n = S_NORMAL;
      end

      S_FAULT: begin
        cand_n = S_IDLE;
        cnt_n  = '0;
        wd_n   = '0;
        if (bus.fault_clear) begin
          state_n = S_IDLE;
          cause_n = CAUSE_NONE;
        end
      end

      default: begin
        if (!bus.enable) begin
          state_n = S_IDLE;
          cand_n  = S_IDLE;
          cnt_n   = '0;
          wd_n    = '0;
        end else if (!bus.sensor_valid) begin
          // A gap only ages the watchdog; the persistence count survives it
          if (TIMEOUT > 0) begin
            if (wd_cnt == WD_LAST) begin
              state_n = S_FAULT;
              cause_n = CAUSE_WDOG;
              cand_n  = S_IDLE;
              cnt_n   = '0;
              wd_n    = '0;
            end else begin
              wd_n = wd_cnt + 1'b1;
            end
          end
        end else begin
          wd_n = '0;
          if (value_ext >= FAULT_L)
            target = S_FAULT;
          else if (value_ext >= WARN_L)
            target = (state == S_NORMAL) ? S_WARNING : S_IDLE;
          else if (value_ext < OK_L)
            target = (state == S_WARNING) ? S_NORMAL : S_IDLE;
          else
            target = S_IDLE;

          if (target == S_IDLE) begin
            cnt_n = '0;
          end else begin
            if (target == cand) begin
              cnt_inc = cnt + 1'b1;
            end else begin
              cand_n  = target;
              cnt_inc = CNT_W'(1);
            end
            cnt_n = cnt_inc;
            if (cnt_inc == PERSIST_L) begin
              state_n = target;
              cnt_n   = '0;
              if (target == S_FAULT) cause_n = CAUSE_THRESH;
            end
          end
        end
      end
    endcase
  end

  assign bus.system_state  = state;
  assign bus.state_changed = changed;
  assign bus.fault_cause   = cause;

endmodule

// File: tb/tb_system_state_fsm.sv
// Bench for system_state_fsm: directed vector table, hand sequences for the
// watchdog and async-reset corners, then random stimulus against a queue-based model.
module tb_system_state_fsm;

  localparam int DATA_W   = 12;
  localparam int WARN_TH  = 2048;
  localparam int FAULT_TH = 3072;
  localparam int HYST     = 128;
  localparam int PERSIST  = 3;
  localparam int TIMEOUT  = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  system_state_if #(.DATA_W(DATA_W)) bus ();

  system_state_fsm #(
    .DATA_W(DATA_W), .WARN_TH(WARN_TH), .FAULT_TH(FAULT_TH),
    .HYST(HYST), .PERSIST(PERSIST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit       en;
    bit       vld;
    int       val;
    bit       clr;
    bit [1:0] st;
    bit       ch;
    bit [1:0] ca;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit en, bit vld, int val, bit clr, bit [1:0] st, bit ch, bit [1:0] ca);
    vec_t v;
    v.en = en; v.vld = vld; v.val = val; v.clr = clr; v.st = st; v.ch = ch; v.ca = ca;
    vecs.push_back(v);
  endtask

  task automatic check(string name, bit [1:0] st, bit ch, bit [1:0] ca);
    checks++;
    if (bus.system_state !== st || bus.state_changed !== ch || bus.fault_cause !== ca) begin
      errors++;
      $display("FAIL %s: got state=%0d changed=%0d cause=%0d, expected state=%0d changed=%0d cause=%0d",
               name, bus.system_state, bus.state_changed, bus.fault_cause, st, ch, ca);
    end
  endtask

  task automatic drive(bit en, bit vld, int val, bit clr);
    bus.enable       = en;
    bus.sensor_valid = vld;
    bus.sensor_value = DATA_W'(val);
    bus.fault_clear  = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int m_state, m_cause, m_gap;
  bit m_changed;
  int m_hist[$];   // targets of valid samples since the last state change (-1 = none)

  function automatic int sample_target(int st, int val);
    if (val >= FAULT_TH) return 3;
    if (val >= WARN_TH) return (st == 1) ? 2 : -1;
    if (val < WARN_TH - HYST) return (st == 2) ? 1 : -1;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cause = 0; m_gap = 0; m_changed = 0;
    m_hist.delete();
  endtask

  task automatic model_step(bit en, bit vld, int val, bit clr);
    int nxt, ncause, tgt;
    bit agree;
    nxt = m_state;
    ncause = m_cause;
    if (m_state == 0) begin
      m_hist.delete(); m_gap = 0;
      if (en) nxt = 1;
    end else if (m_state == 3) begin
      m_hist.delete(); m_gap = 0;
      if (clr) begin nxt = 0; ncause = 0; end
    end else if (!en) begin
      nxt = 0; m_hist.delete(); m_gap = 0;
    end else if (!vld) begin
      m_gap++;
      if (TIMEOUT > 0 && m_gap >= TIMEOUT) begin
        nxt = 3; ncause = 2; m_hist.delete(); m_gap = 0;
      end
    end else begin
      m_gap = 0;
      tgt = sample_target(m_state, val);
      m_hist.push_back(tgt);
      if (m_hist.size() > PERSIST) void'(m_hist.pop_front());
      agree = (tgt != -1) && (m_hist.size() == PERSIST);
      foreach (m_hist[k]) if (m_hist[k] != tgt) agree = 0;
      if (agree) begin
        nxt = tgt;
        if (tgt == 3) ncause = 1;
        m_hist.delete();
      end
    end
    m_changed = (nxt != m_state);
    m_state = nxt;
    m_cause = ncause;
  endtask

  initial begin
    drive(0, 0, 0, 0);

    // Test 1..4 and enable-drop vectors; expected values are after each edge
    add(1,0,0,0,    2'b01,1,0);
    add(1,0,0,0,    2'b01,0,0);
    add(1,1,2500,0, 2'b01,0,0);
    add(1,1,2500,0, 2'b01,0,0);
    add(1,1,2500,0, 2'b10,1,0);
    add(1,0,0,0,    2'b10,0,0);
    for (int i = 0; i < 5; i++) add(1,1,2000,0, 2'b10,0,0);
    add(1,1,1900,0, 2'b10,0,0);
    add(1,1,1900,0, 2'b10,0,0);
    add(1,1,1900,0, 2'b01,1,0);
    add(1,1,2500,0, 2'b01,0,0);
    add(1,1,1900,0, 2'b01,0,0);
    add(1,1,2500,0, 2'b01,0,0);
    add(1,1,2500,0, 2'b01,0,0);
    add(1,1,1000,0, 2'b01,0,0);
    add(1,1,2500,0, 2'b01,0,0);
    add(1,1,2500,0, 2'b01,0,0);
    add(1,1,1000,0, 2'b01,0,0);
    add(1,1,2500,0, 2'b01,0,0);
    add(1,1,1000,0, 2'b01,0,0);
    add(1,1,3100,0, 2'b01,0,0);
    add(1,1,3100,0, 2'b01,0,0);
    add(1,1,3100,0, 2'b11,1,1);
    add(0,1,3100,0, 2'b11,0,1);
    add(0,1,500,0,  2'b11,0,1);
    add(0,0,0,0,    2'b11,0,1);
    add(1,0,0,1,    2'b00,1,0);
    add(1,0,0,0,    2'b01,1,0);
    add(1,0,0,0,    2'b01,0,0);
    add(0,1,2500,0, 2'b00,1,0);
    add(1,1,2500,0, 2'b01,1,0);
    add(1,1,2500,0, 2'b01,0,0);
    add(1,1,2500,0, 2'b01,0,0);
    add(1,1,2500,0, 2'b10,1,0);
    add(0,0,0,0,    2'b00,1,0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 2'b00, 1'b0, 2'b00);
    reset = 1'b0;
    tick();
    check("idle_hold", 2'b00, 1'b0, 2'b00);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].vld, vecs[i].val, vecs[i].clr);
      tick();
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ch, vecs[i].ca);
    end

    // Watchdog: 999 silent cycles survive, the 1000th trips FAULT
    begin
      bit early;
      drive(1, 0, 0, 0); tick();
      check("wd_enter_normal", 2'b01, 1'b1, 2'b00);
      early = 0;
      for (int i = 0; i < TIMEOUT - 1; i++) begin
        tick();
        if (bus.system_state != 2'b01) early = 1;
      end
      checks++;
      if (early) begin
        errors++;
        $display("FAIL wd_999_quiet: state left NORMAL early, expected 1");
      end
      drive(1, 1, 1000, 0); tick();
      check("wd_valid_rescue", 2'b01, 1'b0, 2'b00);
      drive(1, 0, 0, 0);
      for (int i = 0; i < TIMEOUT - 1; i++) tick();
      check("wd_999_again", 2'b01, 1'b0, 2'b00);
      tick();
      check("wd_expire", 2'b11, 1'b1, 2'b10);
      drive(1, 0, 0, 1); tick();
      check("wd_clear", 2'b00, 1'b1, 2'b00);
      drive(1, 0, 0, 0); tick();
      check("wd_renormal", 2'b01, 1'b1, 2'b00);
    end

    // Async reset mid-cycle discards partial persistence
    drive(1, 1, 2500, 0); tick();
    drive(1, 1, 2500, 0); tick();
    check("ar_two_samples", 2'b01, 1'b0, 2'b00);
    drive(1, 0, 0, 0);
    #3 reset = 1'b1;
    #1 check("ar_immediate", 2'b00, 1'b0, 2'b00);
    tick();
    reset = 1'b0;
    drive(1, 0, 0, 0); tick();
    check("ar_renormal", 2'b01, 1'b1, 2'b00);
    drive(1, 1, 2500, 0); tick();
    check("ar_one_sample", 2'b01, 1'b0, 2'b00);
    drive(1, 0, 0, 0); tick();
    check("ar_still_normal", 2'b01, 1'b0, 2'b00);

    // Random stimulus against the model
    drive(0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit en, vld, clr;
      int val, b;
      en  = ($urandom_range(0, 19) != 0);
      vld = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 9) == 0);
      b   = $urandom_range(0, 9);
      if (b == 0)      val = $urandom_range(FAULT_TH, (1 << DATA_W) - 1);
      else if (b < 4)  val = $urandom_range(WARN_TH, FAULT_TH - 1);
      else if (b < 6)  val = $urandom_range(WARN_TH - HYST, WARN_TH - 1);
      else             val = $urandom_range(0, WARN_TH - HYST - 1);
      drive(en, vld, val, clr);
      model_step(en, vld, val, clr);
      tick();
      check($sformatf("rand%0d", n), 2'(m_state), m_changed, 2'(m_cause));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
